uart_imem_loader: RTL and testbench

- Boot-time controller between the UART receiver and the instruction memory.
- Packs UART bytes little-endian into 32-bit instruction words and writes them to sequential word addresses.
- Holds the CPU in reset until a terminator word arrives, then releases the CPU and asserts write_done.
- Handles inter-byte timeout, BREAK resync and memory overflow.

---
 rtl/uart_imem_loader.sv | 192 +++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Boot-time loader sitting between the UART receiver and the instruction
//   memory. Received bytes are packed little-endian into 32-bit words and
//   written to consecutive word addresses. The CPU is held in reset until the
//   terminator word arrives. Partial words are dropped on inter-byte timeout
//   or BREAK. Words that arrive while the memory is full are dropped and
//   flagged.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   load_en      level-sensitive load enable
//   rx_valid     one-cycle strobe, rx_data holds a received byte
//   rx_data      received byte
//   rx_break     one-cycle strobe, UART BREAK detected
//   mem_we       one-cycle instruction memory write strobe
//   mem_addr     word write address
//   mem_wdata    word write data
//   cpu_rst      active-high reset to the core
//   write_done   sticky, load complete
//   word_count   number of words written so far
//   frame_err    sticky, a partial word was discarded
//   ovf_err      sticky, a word was dropped because the memory was full
module uart_imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic              ovf_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [31:0]       asm_q, asm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic              cpuRst_q, cpuRst_d;
  logic              writeDone_q, writeDone_d;
  logic [CNT_W-1:0]  wordCount_q, wordCount_d;
  logic              frameErr_q, frameErr_d;
  logic              ovfErr_q, ovfErr_d;
  logic [31:0]       fullWord;

  // The word as it will look once the current byte lands in lane 3.
  assign fullWord = {rx_data, asm_q[23:0]};

  // Next-state logic. Priority inside LOAD is abort, then BREAK (which also
  // swallows a simultaneous byte), then byte reception, then the timeout.
  // A full memory is detected by the top bit of word_count, which is set
  // only once exactly 2^ADDR_W words have been written.
  always_comb begin
    state_d     = state_q;
    byteIdx_d   = byteIdx_q;
    asm_d       = asm_q;
    tmo_d       = tmo_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    cpuRst_d    = cpuRst_q;
    writeDone_d = writeDone_q;
    wordCount_d = wordCount_q;
    frameErr_d  = frameErr_q;
    ovfErr_d    = ovfErr_q;

    case (state_q)
      IDLE: begin
        cpuRst_d    = 1'b1;
        byteIdx_d   = '0;
        tmo_d       = '0;
        memAddr_d   = '0;
        wordCount_d = '0;
        if (load_en) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (!load_en) begin
          state_d     = IDLE;
          byteIdx_d   = '0;
          tmo_d       = '0;
          memAddr_d   = '0;
          wordCount_d = '0;
        end else if (rx_break) begin
          if (byteIdx_q != 2'd0) begin
            byteIdx_d  = '0;
            tmo_d      = '0;
            frameErr_d = 1'b1;
          end
        end else if (rx_valid) begin
          tmo_d                          = '0;
          asm_d[{byteIdx_q, 3'b000} +: 8] = rx_data;
          byteIdx_d                      = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'd3) begin
            if (fullWord == END_WORD) begin
              state_d     = DONE;
              writeDone_d = 1'b1;
              cpuRst_d    = 1'b0;
            end else if (!wordCount_q[ADDR_W]) begin
              memWe_d     = 1'b1;
              memWdata_d  = fullWord;
              memAddr_d   = wordCount_q[ADDR_W-1:0];
              wordCount_d = wordCount_q + CNT_W'(1);
            end else begin
              ovfErr_d = 1'b1;
            end
          end
        end else if (byteIdx_q != 2'd0) begin
          // Fires on the TIMEOUT_CYC-th idle cycle, so a byte arriving right
          // after it starts a fresh word.
          if (tmo_q == TMO_LAST) begin
            byteIdx_d  = '0;
            tmo_d      = '0;
            frameErr_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      DONE: begin
        cpuRst_d    = 1'b0;
        writeDone_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any partial word without writing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byteIdx_q   <= '0;
      asm_q       <= '0;
      tmo_q       <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      cpuRst_q    <= 1'b1;
      writeDone_q <= 1'b0;
      wordCount_q <= '0;
      frameErr_q  <= 1'b0;
      ovfErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteIdx_q   <= byteIdx_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      cpuRst_q    <= cpuRst_d;
      writeDone_q <= writeDone_d;
      wordCount_q <= wordCount_d;
      frameErr_q  <= frameErr_d;
      ovfErr_q    <= ovfErr_d;
    end
  end

  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign cpu_rst    = cpuRst_q;
  assign write_done = writeDone_q;
  assign word_count = wordCount_q;
  assign frame_err  = frameErr_q;
  assign ovf_err    = ovfErr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed testbench for uart_imem_loader. Two instances share the same
// stimulus: a full-size one (ADDR_W=8) and a tiny one (ADDR_W=2) that is used
// to exercise memory overflow.
module tb_uart_imem_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;

  logic        memWe, cpuRst, writeDone, frameErr, ovfErr;
  logic [7:0]  memAddr;
  logic [31:0] memWdata;
  logic [8:0]  wordCount;

  logic        sMemWe, sCpuRst, sWriteDone, sFrameErr, sOvfErr;
  logic [1:0]  sMemAddr;
  logic [31:0] sMemWdata;
  logic [2:0]  sWordCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrData[$];
  logic [7:0]  wrAddr[$];
  logic [31:0] sWrData[$];
  logic [1:0]  sWrAddr[$];
  logic [7:0]  byteQ[$];

  uart_imem_loader #(.ADDR_W(8), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(memWe), .mem_addr(memAddr),
    .mem_wdata(memWdata), .cpu_rst(cpuRst), .write_done(writeDone),
    .word_count(wordCount), .frame_err(frameErr), .ovf_err(ovfErr)
  );

  uart_imem_loader #(.ADDR_W(2), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(TMO)) dutSmall (
    .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(sMemWe), .mem_addr(sMemAddr),
    .mem_wdata(sMemWdata), .cpu_rst(sCpuRst), .write_done(sWriteDone),
    .word_count(sWordCount), .frame_err(sFrameErr), .ovf_err(sOvfErr)
  );

  always #5 clk = ~clk;

  // Record every memory write shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (memWe) begin
      wrData.push_back(memWdata);
      wrAddr.push_back(memAddr);
    end
    if (sMemWe) begin
      sWrData.push_back(sMemWdata);
      sWrAddr.push_back(sMemAddr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] wd(input int i);
    return (wrData.size() > i) ? wrData[i] : 32'hBAD0_BAD0;
  endfunction
  function automatic logic [7:0] wa(input int i);
    return (wrAddr.size() > i) ? wrAddr[i] : 8'hEE;
  endfunction
  function automatic logic [31:0] swd(input int i);
    return (sWrData.size() > i) ? sWrData[i] : 32'hBAD0_BAD0;
  endfunction
  function automatic logic [1:0] swa(input int i);
    return (sWrAddr.size() > i) ? sWrAddr[i] : 2'bxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte strobe followed by an idle cycle.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendWordSlow(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8]);
  endtask

  task automatic queueWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) byteQ.push_back(w[8*i +: 8]);
  endtask

  // Sends every queued byte on consecutive cycles with no gaps.
  task automatic flushBytes();
    while (byteQ.size() > 0) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = byteQ.pop_front();
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulseBreak(input logic withByte, input logic [7:0] b);
    @(negedge clk);
    rx_break = 1'b1;
    rx_valid = withByte;
    rx_data  = b;
    @(negedge clk);
    rx_break = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst      = 1'b1;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    wrData.delete();
    wrAddr.delete();
    sWrData.delete();
    sWrAddr.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic startLoad();
    load_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    resetDut();
    checkOutput("rst_cpu_rst",    64'(cpuRst),    64'h1);
    checkOutput("rst_mem_we",     64'(memWe),     64'h0);
    checkOutput("rst_mem_addr",   64'(memAddr),   64'h0);
    checkOutput("rst_mem_wdata",  64'(memWdata),  64'h0);
    checkOutput("rst_write_done", 64'(writeDone), 64'h0);
    checkOutput("rst_word_count", 64'(wordCount), 64'h0);
    checkOutput("rst_flags",      64'({frameErr, ovfErr}), 64'h0);

    // First word: 13 01 01 FC
    startLoad();
    sendWordSlow(32'hFC01_0113);
    checkOutput("w1_mem_we",     64'(memWe),     64'h1);
    checkOutput("w1_mem_addr",   64'(memAddr),   64'h0);
    checkOutput("w1_mem_wdata",  64'(memWdata),  64'hFC01_0113);
    checkOutput("w1_word_count", 64'(wordCount), 64'h1);
    checkOutput("w1_cpu_rst",    64'(cpuRst),    64'h1);
    @(negedge clk);
    checkOutput("w1_we_pulse",   64'(memWe),     64'h0);

    // Abort mid-word, then reload from address 0
    applyStimulus(8'hAA);
    load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_word_count", 64'(wordCount), 64'h0);
    checkOutput("abort_cpu_rst",    64'(cpuRst),    64'h1);
    startLoad();
    sendWordSlow(32'h0000_0293);
    checkOutput("abort_reload_addr", 64'(memAddr),  64'h0);
    checkOutput("abort_reload_data", 64'(memWdata), 64'h0000_0293);

    // Three words back-to-back, then the terminator
    resetDut();
    startLoad();
    queueWord(32'h0000_0013);
    queueWord(32'h00A0_0093);
    queueWord(32'h00B0_0113);
    queueWord(32'hFFFF_FFFF);
    flushBytes();
    checkOutput("done_write_done", 64'(writeDone), 64'h1);
    checkOutput("done_cpu_rst",    64'(cpuRst),    64'h0);
    checkOutput("done_nwrites",    64'(wrData.size()), 64'd3);
    checkOutput("done_addr0",      64'(wa(0)), 64'h0);
    checkOutput("done_addr1",      64'(wa(1)), 64'h1);
    checkOutput("done_addr2",      64'(wa(2)), 64'h2);
    checkOutput("done_data1",      64'(wd(1)), 64'h00A0_0093);
    checkOutput("done_data2",      64'(wd(2)), 64'h00B0_0113);
    checkOutput("done_word_count", 64'(wordCount), 64'h3);
    sendWordSlow(32'h1122_3344);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_no_more_writes", 64'(wrData.size()), 64'd3);
    checkOutput("done_sticky",         64'({writeDone, cpuRst}), 64'h2);

    // Inter-byte timeout
    resetDut();
    startLoad();
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    repeat (TMO - 1) @(negedge clk);
    checkOutput("tmo_not_yet", 64'(frameErr), 64'h0);
    @(negedge clk);
    checkOutput("tmo_fired",   64'(frameErr), 64'h1);
    sendWordSlow(32'h0010_0093);
    checkOutput("tmo_nwrites", 64'(wrData.size()), 64'd1);
    checkOutput("tmo_data",    64'(wd(0)), 64'h0010_0093);
    checkOutput("tmo_addr",    64'(wa(0)), 64'h0);

    // BREAK handling
    resetDut();
    startLoad();
    pulseBreak(1'b1, 8'h99);
    checkOutput("brk_idle_noerr", 64'(frameErr), 64'h0);
    applyStimulus(8'h55);
    pulseBreak(1'b1, 8'h77);
    checkOutput("brk_frame_err", 64'(frameErr), 64'h1);
    sendWordSlow(32'hDEAD_BEEF);
    checkOutput("brk_nwrites", 64'(wrData.size()), 64'd1);
    checkOutput("brk_data",    64'(wd(0)), 64'hDEAD_BEEF);
    checkOutput("brk_addr",    64'(wa(0)), 64'h0);

    // Overflow on the ADDR_W=2 instance
    resetDut();
    startLoad();
    for (int i = 0; i < 5; i++) queueWord(32'h0000_0013 + (i << 20));
    queueWord(32'hFFFF_FFFF);
    flushBytes();
    checkOutput("ovf_s_nwrites", 64'(sWrData.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_s_addr%0d", i), 64'(swa(i)), 64'(i));
      checkOutput($sformatf("ovf_s_data%0d", i), 64'(swd(i)), 64'(32'h0000_0013 + (i << 20)));
    end
    checkOutput("ovf_s_err",        64'(sOvfErr),    64'h1);
    checkOutput("ovf_s_word_count", 64'(sWordCount), 64'h4);
    checkOutput("ovf_s_done",       64'(sWriteDone), 64'h1);
    checkOutput("ovf_b_nwrites",    64'(wrData.size()), 64'd5);
    checkOutput("ovf_b_data4",      64'(wd(4)), 64'h0040_0013);
    checkOutput("ovf_b_err",        64'(ovfErr),     64'h0);
    checkOutput("ovf_b_word_count", 64'(wordCount),  64'h5);

    // Reset in the middle of a word
    resetDut();
    startLoad();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    resetDut();
    startLoad();
    sendWordSlow(32'h1234_5678);
    checkOutput("mid_rst_nwrites", 64'(wrData.size()), 64'd1);
    checkOutput("mid_rst_addr",    64'(wa(0)), 64'h0);
    checkOutput("mid_rst_data",    64'(wd(0)), 64'h1234_5678);
    checkOutput("mid_rst_flags",   64'({frameErr, ovfErr, writeDone}), 64'h0);
    checkOutput("mid_rst_count",   64'(wordCount), 64'h1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
